dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory port: word-addressed RAM behind a valid/ready

---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/dmem_responder_ram.sv | 32 +++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-port responders and initiators:
// FSM encoding, request record layout and access-error codes.
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = WORD_BYTES;
  localparam int WAIT_CNT_W = 4;

  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/dmem_responder_ram.sv
// Word-wide storage with byte-enable synchronous write, combinational read
// and an asynchronous clear of every word.
module dmem_responder_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one request, waits WAIT_CYCLES, performs the
// RAM access, then holds the response until the initiator takes it.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output mem_state_e        state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid must then stay asserted and its payload stable until that edge.

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t                req_q, req_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [29:0]             word_off;
  logic                    addr_err;
  logic                    ram_we;
  logic [DATA_W-1:0]       ram_rdata;

  // Unsigned wrap of the subtraction is caught by the addr < BASE_ADDR term.
  assign word_off = 30'((req_q.addr - BASE_ADDR) >> 2);
  assign addr_err = (req_q.addr < BASE_ADDR) ||
                    ({2'b00, word_off} >= 32'(DEPTH_WORDS)) ||
                    (req_q.addr[1:0] != 2'b00);
  assign ram_we   = (state_q == ST_WAIT) && (cnt_q == '0) && req_q.write && !addr_err;

  dmem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .idx_i   (word_off[IDX_W-1:0]),
    .be_i    (req_q.be),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end else begin
          err_d   = addr_err ? ERR_ACCESS : ERR_NONE;
          rdata_d = (req_q.write || addr_err) ? '0 : ram_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states, one with none; shared
// request bus, per-instance req_valid, outputs selected by sel.
module tb_dmem_responder;
  import mips_mem_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_a, req_valid_b, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  mem_state_e  a_state;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  mem_state_e  b_state;

  logic        sel = 1'b0;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cur_req_ready = sel ? b_req_ready : a_req_ready;
  assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign cur_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign cur_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .state_dbg(a_state)
  );

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .state_dbg(b_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) req_valid_b = v;
    else     req_valid_a = v;
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  // Count edges after the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (!cur_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_txn(input vec_t v, input int exp_lat, input string name);
    int n;
    @(negedge clk);
    check({name, " req_ready"}, 32'(cur_req_ready), 32'd1);
    drive_req(v.wr, v.addr, v.wdata, v.be);
    set_valid(1'b1);
    @(posedge clk);
    #1 set_valid(1'b0);
    wait_rsp(n);
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " rdata"}, cur_rsp_rdata, v.exp_rdata);
    check({name, " err"}, 32'(cur_rsp_err), 32'(v.exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({name, " idle rsp_valid"}, 32'(cur_rsp_valid), 32'd0);
    check({name, " idle req_ready"}, 32'(cur_req_ready), 32'd1);
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    int n;
    int got;
    logic [31:0] b_addrs [4];
    logic [31:0] b_data  [4];

    vecs.push_back(mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0));
    vecs.push_back(mk(1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h3FC, 32'h12345678, 4'h0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h3FC, 32'hCAFEF00D, 4'h8, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCA000000, 1'b0));
    vecs.push_back(mk(1'b1, 32'h3F8, 32'h01020304, 4'h3, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h3F8, 32'h0,        4'h0, 32'h00000304, 1'b0));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0,        1'b1));

    // Clock/reset
    req_valid_a = 1'b0; req_valid_b = 1'b0; rsp_ready = 1'b0;
    drive_req(1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("reset a req_ready", 32'(a_req_ready), 32'd1);
    check("reset a rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("reset a rsp_rdata", a_rsp_rdata, 32'h0);
    check("reset a rsp_err",   32'(a_rsp_err), 32'd0);
    check("reset a state",     32'(a_state), 32'(ST_IDLE));
    check("reset b state",     32'(b_state), 32'(ST_IDLE));

    // Reset in the middle of a WAIT abandons the store
    sel = 1'b0;
    drive_req(1'b1, 32'h10, 32'h55555555, 4'hF);
    set_valid(1'b1);
    @(posedge clk);
    #1 set_valid(1'b0);
    @(posedge clk);
    #1;
    check("mid-wait state", 32'(a_state), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check("async rst req_ready", 32'(a_req_ready), 32'd1);
    check("async rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("async rst rsp_err",   32'(a_rsp_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_txn(mk(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0), 3, "post-reset load 0x10");

    // Table-driven vectors on the two-wait-state instance
    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], 3, $sformatf("vec%0d", i));
    end

    // Backpressure: response held 5 cycles, a request pulse must be ignored
    @(negedge clk);
    drive_req(1'b0, 32'h10, 32'h0, 4'h0);
    set_valid(1'b1);
    @(posedge clk);
    #1 set_valid(1'b0);
    wait_rsp(n);
    check("bp latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d rsp_valid", i), 32'(a_rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_rdata", i), a_rsp_rdata, 32'hDEADBEEF);
      check($sformatf("bp%0d req_ready", i), 32'(a_req_ready), 32'd0);
      if (i == 1) begin
        drive_req(1'b1, 32'h10, 32'h0, 4'hF);
        set_valid(1'b1);
      end
      if (i == 3) set_valid(1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    run_txn(mk(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0), 3, "bp reload 0x10");

    // Zero-wait instance: seed two words, then stream loads with rsp_ready high
    sel = 1'b1;
    run_txn(mk(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0), 1, "b store 0x0");
    run_txn(mk(1'b1, 32'h4, 32'h01020304, 4'hF, 32'h0, 1'b0), 1, "b store 0x4");
    b_addrs[0] = 32'h0; b_data[0] = 32'hA5A5A5A5;
    b_addrs[1] = 32'h4; b_data[1] = 32'h01020304;
    b_addrs[2] = 32'h8; b_data[2] = 32'h00000000;
    b_addrs[3] = 32'h0; b_data[3] = 32'hA5A5A5A5;
    n = 0;
    got = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(1'b0, b_addrs[0], 32'h0, 4'h0);
    set_valid(1'b1);
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (b_rsp_valid) begin
        check($sformatf("b stream%0d rdata", got), b_rsp_rdata, exp_q.pop_front());
        check($sformatf("b stream%0d cycle", got), 32'(cyc), 32'(exp_cyc_q.pop_front()));
        got++;
      end
      if (b_req_ready && req_valid_b) begin
        exp_q.push_back(b_data[n]);
        exp_cyc_q.push_back(cyc + 2);
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && req_valid_b && b_state == ST_WAIT) begin
        n++;
        if (n < 4) drive_req(1'b0, b_addrs[n], 32'h0, 4'h0);
        else       set_valid(1'b0);
      end
      @(negedge clk);
    end
    check("b stream responses", 32'(got), 32'd4);
    rsp_ready = 1'b0;
    set_valid(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
